ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 33 +++
 rtl/ram_arbiter.sv | 127 ++++++++++++
 tb/tb_ram_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: two requester ports, the RAM command/response
// channel and the conflict counter. The arbiter uses the slave view; the
// requesters and the RAM model together use the master view.
interface ram_arbiter_if;
  logic        req0, req1;
  logic        we0, we1;
  logic [2:0]  access0, access1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1;
  logic        rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        err0, err1;
  logic        ram_load, ram_store;
  logic [2:0]  ram_access;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata;
  logic [15:0] conflict_cnt;

  modport slave (
    input  req0, req1, we0, we1, access0, access1, addr0, addr1, wdata0, wdata1,
    input  ram_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
    output ram_load, ram_store, ram_access, ram_addr, ram_wdata, conflict_cnt
  );

  modport master (
    output req0, req1, we0, we1, access0, access1, addr0, addr1, wdata0, wdata1,
    output ram_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
    input  ram_load, ram_store, ram_access, ram_addr, ram_wdata, conflict_cnt
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported RAM. Each access
// takes an ISSUE cycle (RAM strobes) and a RESP cycle (completion pulse),
// with illegal accesses completing with err and no RAM side effect.
module ram_arbiter #(
  parameter int unsigned ADDR_LIMIT = 4096
) (
  input logic          clk,
  input logic          rstn,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e      state_q, state_d;
  logic        port_q;  // winner of the latest arbitration, doubles as last-grant
  logic        we_q;
  logic [2:0]  access_q;
  logic [31:0] addr_q, wdata_q;
  logic [15:0] cnt_q;

  logic any_req, both_req, arb, win;
  logic bad_code, misalign, out_of_range, illegal, load_ok;

  assign any_req  = bus.req0 | bus.req1;
  assign both_req = bus.req0 & bus.req1;
  // On a tie the port that did not win last time is served.
  assign win      = both_req ? ~port_q : bus.req1;
  assign arb      = ((state_q == StIdle) || (state_q == StResp)) && any_req;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: state_d = StResp;
      StResp:  state_d = any_req ? StIssue : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the winner's command and count ties on every arbitration edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      port_q   <= 1'b1;
      we_q     <= 1'b0;
      access_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
    end else if (arb) begin
      port_q   <= win;
      we_q     <= win ? bus.we1 : bus.we0;
      access_q <= win ? bus.access1 : bus.access0;
      addr_q   <= win ? bus.addr1 : bus.addr0;
      wdata_q  <= win ? bus.wdata1 : bus.wdata0;
      if (both_req && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
    end
  end

  // Legality of the latched access: code, alignment and address range
  always_comb begin
    bad_code = 1'b0;
    misalign = 1'b0;
    unique case (access_q)
      3'b000, 3'b100: misalign = 1'b0;
      3'b001, 3'b101: misalign = addr_q[0];
      3'b010:         misalign = |addr_q[1:0];
      default:        bad_code = 1'b1;
    endcase
  end

  assign out_of_range = addr_q >= ADDR_LIMIT;
  assign illegal      = bad_code | misalign | out_of_range | (we_q & access_q[2]);
  assign load_ok      = ~we_q & ~illegal;

  // Port-side and RAM-side outputs; everything idles at zero
  always_comb begin
    bus.gnt0       = 1'b0;
    bus.gnt1       = 1'b0;
    bus.rvalid0    = 1'b0;
    bus.rvalid1    = 1'b0;
    bus.rdata0     = '0;
    bus.rdata1     = '0;
    bus.err0       = 1'b0;
    bus.err1       = 1'b0;
    bus.ram_load   = 1'b0;
    bus.ram_store  = 1'b0;
    bus.ram_access = '0;
    bus.ram_addr   = '0;
    bus.ram_wdata  = '0;
    unique case (state_q)
      StIssue: begin
        if (port_q) bus.gnt1 = 1'b1;
        else        bus.gnt0 = 1'b1;
        bus.ram_access = access_q;
        bus.ram_addr   = addr_q;
        bus.ram_wdata  = wdata_q;
        bus.ram_load   = load_ok;
        bus.ram_store  = we_q & ~illegal;
      end
      StResp: begin
        if (port_q) begin
          bus.rvalid1 = 1'b1;
          bus.err1    = illegal;
          bus.rdata1  = load_ok ? bus.ram_rdata : '0;
        end else begin
          bus.rvalid0 = 1'b1;
          bus.err0    = illegal;
          bus.rdata0  = load_ok ? bus.ram_rdata : '0;
        end
      end
      default: ;
    endcase
  end

  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a stimulus process models arbitration and
// memory contents at transaction level and queues expected responses; a
// negedge monitor compares every cycle's outputs against the queue head.
module tb_ram_arbiter;

  localparam int unsigned ADDR_LIMIT = 4096;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ram_arbiter_if bus ();

  ram_arbiter #(.ADDR_LIMIT(ADDR_LIMIT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    int          port;
    int          gnt_cyc;
    int          rv_cyc;
    bit          ld;
    bit          st;
    bit          err;
    logic [66:0] cmd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  int          gnt_log[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;

  // Reference model state
  logic [7:0]  mem_ref [4096];
  bit          busy = 1'b0;
  int          last_ref = 1;
  logic [15:0] cnt_ref = '0;

  // Requester state
  bit          pend [2];
  bit          p_we [2];
  logic [2:0]  p_acc [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];

  // Monitor observations
  int          rv_count [2];
  logic [31:0] last_rdata [2];
  logic        last_err [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int acc_size(input logic [2:0] acc);
    case (acc)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit is_legal(input bit we, input logic [2:0] acc, input logic [31:0] a);
    int sz = acc_size(acc);
    if (sz == 0) return 1'b0;
    if (we && acc[2]) return 1'b0;
    if ((a % 32'(sz)) != 32'd0) return 1'b0;
    if (a >= 32'(ADDR_LIMIT)) return 1'b0;
    return 1'b1;
  endfunction

  // Little-endian read with sign extension for the signed codes
  function automatic logic [31:0] ref_load(input logic [2:0] acc, input logic [31:0] a);
    logic [31:0] v = '0;
    int sz = acc_size(acc);
    for (int i = 0; i < sz; i++) v[8*i +: 8] = mem_ref[int'(a) + i];
    if (!acc[2] && (sz < 4) && v[8*sz-1]) begin
      for (int i = 8*sz; i < 32; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] acc, input logic [31:0] a, input logic [31:0] d);
    int sz = acc_size(acc);
    for (int i = 0; i < sz; i++) mem_ref[int'(a) + i] = d[8*i +: 8];
  endtask

  // RAM stand-in: registered read data, one cycle after ram_load
  bit          ram_init;
  logic [7:0]  mem_ram [4096];
  int          rs;
  logic [31:0] rv;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 4096; i++) mem_ram[i] <= 8'(i * 37 + 11);
      ram_init <= 1'b1;
    end else begin
      rs = acc_size(bus.ram_access);
      if (bus.ram_store) begin
        for (int i = 0; i < rs; i++) begin
          if (bus.ram_addr + 32'(i) < 32'd4096)
            mem_ram[int'(bus.ram_addr) + i] <= bus.ram_wdata[8*i +: 8];
        end
      end
      if (bus.ram_load) begin
        rv = '0;
        for (int i = 0; i < rs; i++) begin
          if (bus.ram_addr + 32'(i) < 32'd4096) rv[8*i +: 8] = mem_ram[int'(bus.ram_addr) + i];
        end
        if (!bus.ram_access[2] && (rs > 0) && (rs < 4) && rv[8*rs-1]) begin
          for (int i = 8*rs; i < 32; i++) rv[i] = 1'b1;
        end
        bus.ram_rdata <= rv;
      end
    end
  end

  // Monitor: compare outputs each cycle against the scoreboard head
  exp_t        me;
  logic [1:0]  eg, er;
  logic        el, es;
  logic [66:0] ecmd;
  logic [65:0] eresp;
  always @(negedge clk) begin
    eg = '0; er = '0; el = 1'b0; es = 1'b0; ecmd = '0; eresp = '0;
    if (sb_q.size() != 0) begin
      me = sb_q[0];
      if (me.gnt_cyc == cyc) begin
        if (me.port == 1) eg[1] = 1'b1;
        else              eg[0] = 1'b1;
        el   = me.ld;
        es   = me.st;
        ecmd = me.cmd;
      end
      if (me.rv_cyc == cyc) begin
        if (me.port == 1) begin
          er[1] = 1'b1;
          eresp[65:33] = {me.rdata, me.err};
        end else begin
          er[0] = 1'b1;
          eresp[32:0] = {me.rdata, me.err};
        end
      end
    end
    check("gnt", {bus.gnt1, bus.gnt0}, eg);
    check("ram_strobe", {bus.ram_load, bus.ram_store}, {el, es});
    if (eg != 2'b00) check("ram_cmd", {bus.ram_access, bus.ram_addr, bus.ram_wdata}, ecmd);
    check("rvalid", {bus.rvalid1, bus.rvalid0}, er);
    check("resp", {bus.rdata1, bus.err1, bus.rdata0, bus.err0}, eresp);
    check("conflict_cnt", bus.conflict_cnt, cnt_ref);
    if (bus.gnt0) gnt_log.push_back(0);
    if (bus.gnt1) gnt_log.push_back(1);
    if (bus.rvalid0) begin rv_count[0]++; last_rdata[0] = bus.rdata0; last_err[0] = bus.err0; end
    if (bus.rvalid1) begin rv_count[1]++; last_rdata[1] = bus.rdata1; last_err[1] = bus.err1; end
    if ((sb_q.size() != 0) && (sb_q[0].rv_cyc <= cyc)) void'(sb_q.pop_front());
  end

  task automatic new_req(input int p, input bit we, input logic [2:0] acc,
                         input logic [31:0] a, input logic [31:0] d);
    pend[p] = 1'b1; p_we[p] = we; p_acc[p] = acc; p_addr[p] = a; p_wdata[p] = d;
  endtask

  task automatic rand_req(input int p);
    logic [31:0] a;
    if ($urandom_range(0, 9) == 0) a = 32'd4088 + $urandom_range(0, 15);
    else                           a = $urandom_range(0, 63);
    new_req(p, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
  endtask

  // Pending ports hold their fields; idle ports show garbage with req low
  task automatic drive();
    bus.req0    = pend[0];
    bus.we0     = pend[0] ? p_we[0]    : 1'($urandom_range(0, 1));
    bus.access0 = pend[0] ? p_acc[0]   : 3'($urandom_range(0, 7));
    bus.addr0   = pend[0] ? p_addr[0]  : $urandom;
    bus.wdata0  = pend[0] ? p_wdata[0] : $urandom;
    bus.req1    = pend[1];
    bus.we1     = pend[1] ? p_we[1]    : 1'($urandom_range(0, 1));
    bus.access1 = pend[1] ? p_acc[1]   : 3'($urandom_range(0, 7));
    bus.addr1   = pend[1] ? p_addr[1]  : $urandom;
    bus.wdata1  = pend[1] ? p_wdata[1] : $urandom;
  endtask

  // One clock edge of the transaction-level model
  task automatic step();
    exp_t e;
    int   w;
    bit   ok;
    @(posedge clk);
    #1;
    if (!busy && (pend[0] || pend[1])) begin
      if (pend[0] && pend[1]) begin
        if (cnt_ref != 16'hFFFF) cnt_ref = cnt_ref + 16'd1;
        w = (last_ref == 1) ? 0 : 1;
      end else begin
        w = pend[1] ? 1 : 0;
      end
      last_ref  = w;
      busy      = 1'b1;
      ok        = is_legal(p_we[w], p_acc[w], p_addr[w]);
      e.port    = w;
      e.gnt_cyc = cyc;
      e.rv_cyc  = cyc + 1;
      e.ld      = ok && !p_we[w];
      e.st      = ok && p_we[w];
      e.err     = !ok;
      e.cmd     = {p_acc[w], p_addr[w], p_wdata[w]};
      e.rdata   = (ok && !p_we[w]) ? ref_load(p_acc[w], p_addr[w]) : 32'd0;
      if (ok && p_we[w]) ref_store(p_acc[w], p_addr[w], p_wdata[w]);
      sb_q.push_back(e);
      pend[w] = 1'b0;
    end else begin
      busy = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((pend[0] || pend[1] || busy || (sb_q.size() != 0)) && (n < 40)) begin
      step();
      drive();
      n++;
    end
    n_checks++;
    if (n >= 40) begin
      n_fail++;
      $display("FAIL drain_timeout: still busy after %0d cycles, need idle", n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rstn = 1'b0;
    sb_q.delete();
    busy = 1'b0; last_ref = 1; cnt_ref = '0; pend[0] = 1'b0; pend[1] = 1'b0;
    drive();
    @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  int rvc;
  logic [5:0] order;

  initial begin
    for (int i = 0; i < 4096; i++) mem_ref[i] = 8'(i * 37 + 11);
    pend[0] = 1'b0; pend[1] = 1'b0;
    rv_count[0] = 0; rv_count[1] = 0;
    rstn = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;

    // Word store then load on port 1
    new_req(1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF); drive(); drain();
    new_req(1, 1'b0, 3'b010, 32'h10, 32'h0); drive(); drain();
    check("s1_rdata", last_rdata[1], 32'hDEADBEEF);
    check("s1_err", last_err[1], 1'b0);

    // Misaligned halfword load
    new_req(1, 1'b0, 3'b001, 32'h13, 32'h0); drive(); drain();
    check("lh_mis_err", last_err[1], 1'b1);
    check("lh_mis_rdata", last_rdata[1], 32'h0);

    // Byte store of 0x80, then signed and unsigned byte loads
    new_req(1, 1'b1, 3'b000, 32'h20, 32'h80); drive(); drain();
    new_req(1, 1'b0, 3'b000, 32'h20, 32'h0); drive(); drain();
    check("lb_rdata", last_rdata[1], 32'hFFFFFF80);
    new_req(1, 1'b0, 3'b100, 32'h20, 32'h0); drive(); drain();
    check("lbu_rdata", last_rdata[1], 32'h00000080);

    // Store at the address limit
    new_req(1, 1'b1, 3'b010, 32'h1000, 32'h12345678); drive(); drain();
    check("oor_err", last_err[1], 1'b1);

    // Continuous requests on both ports after reset: 0,1,0,1,0,1
    do_reset();
    gnt_log.delete();
    new_req(0, 1'b0, 3'b010, 32'h4, 32'h0);
    new_req(1, 1'b0, 3'b010, 32'h8, 32'h0);
    drive();
    for (int k = 0; k < 8; k++) begin
      step();
      if (!pend[0]) new_req(0, 1'b0, 3'b010, 32'h4, 32'h0);
      if (!pend[1]) new_req(1, 1'b0, 3'b010, 32'h8, 32'h0);
      drive();
    end
    drain();
    order = '0;
    for (int k = 0; k < 6 && k < gnt_log.size(); k++) order[k] = (gnt_log[k] == 1);
    check("tie_order", {32'(gnt_log.size()), order}, {32'd6, 6'b101010});
    check("tie_cnt", bus.conflict_cnt, 16'd5);

    // Reset during ISSUE drops the access; the reissue completes normally
    rvc = rv_count[1];
    new_req(1, 1'b0, 3'b010, 32'h10, 32'h0); drive();
    step();
    #1 rstn = 1'b0;
    #1;
    check("rst_async_out", {bus.gnt0, bus.gnt1, bus.ram_load, bus.ram_store, bus.ram_addr},
          '0);
    check("rst_async_cnt", bus.conflict_cnt, 16'd0);
    sb_q.delete();
    busy = 1'b0; last_ref = 1; cnt_ref = '0; pend[1] = 1'b1;
    @(posedge clk);
    #2 rstn = 1'b1;
    drive();
    drain();
    check("rst_reissue", {32'(rv_count[1] - rvc), last_rdata[1]}, {32'd1, 32'hDEADBEEF});

    // Randomized traffic on both ports
    for (int k = 0; k < 1500; k++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 2) != 0)) rand_req(p);
      end
      drive();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
